// File: rtl/esc_sequencer.sv
// ESC sequencer: arming/failsafe state machine feeding slew-limited PWM duty
// values to a four-channel PWM core, updated once per frame.
module esc_sequencer #(
    parameter int CW             = 32,
    parameter int PERIOD_TICKS   = 2000000,
    parameter int MIN_TICKS      = 100000,
    parameter int TICKS_PER_UNIT = 100,
    parameter int MAX_THR        = 1000,
    parameter int MAX_STEP       = 5000,
    parameter int ARM_FRAMES     = 100,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm_req,
    input  logic          disarm_req,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [10:0]   cmd_thr0,
    input  logic [10:0]   cmd_thr1,
    input  logic [10:0]   cmd_thr2,
    input  logic [10:0]   cmd_thr3,
    output logic [CW-1:0] period,
    output logic [CW-1:0] duty0,
    output logic [CW-1:0] duty1,
    output logic [CW-1:0] duty2,
    output logic [CW-1:0] duty3,
    output logic          frame_tick,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    localparam logic [CW-1:0] PERIOD_C   = CW'(PERIOD_TICKS);
    localparam logic [CW-1:0] LAST_C     = CW'(PERIOD_TICKS - 1);
    localparam logic [CW-1:0] MIN_C      = CW'(MIN_TICKS);
    localparam logic [CW-1:0] STEP_C     = CW'(MAX_STEP);
    localparam logic [CW-1:0] TPU_C      = CW'(TICKS_PER_UNIT);
    localparam logic [10:0]   MAXTHR_C   = 11'(MAX_THR);
    localparam logic [15:0]   ARM_LAST_C = 16'(ARM_FRAMES - 1);
    localparam logic [15:0]   TO_LAST_C  = 16'(TIMEOUT_FRAMES - 1);

    function automatic logic [CW-1:0] target_of(input logic [10:0] thr);
        logic [10:0] thr_c;
        thr_c = (thr > MAXTHR_C) ? MAXTHR_C : thr;
        return MIN_C + CW'(thr_c) * TPU_C;
    endfunction

    // Move from 'from' toward 'tgt' by at most STEP_C, never overshooting.
    function automatic logic [CW-1:0] slew(input logic [CW-1:0] from, input logic [CW-1:0] tgt);
        logic [CW-1:0] diff;
        if (tgt >= from) begin
            diff = tgt - from;
            return from + ((diff > STEP_C) ? STEP_C : diff);
        end else begin
            diff = from - tgt;
            return from - ((diff > STEP_C) ? STEP_C : diff);
        end
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          tick_r, tick_s;
    logic [15:0]   arm_cnt_r, arm_cnt_s;
    logic [15:0]   to_cnt_r, to_cnt_s;
    logic          restart_r, restart_s;
    logic          ready_r, ready_s;
    logic [CW-1:0] shadow_r [4];
    logic [CW-1:0] shadow_s [4];
    logic [CW-1:0] duty_r [4];
    logic [CW-1:0] duty_s [4];
    logic [CW-1:0] tgt_s [4];
    logic          accept_s;

    assign tgt_s[0] = target_of(cmd_thr0);
    assign tgt_s[1] = target_of(cmd_thr1);
    assign tgt_s[2] = target_of(cmd_thr2);
    assign tgt_s[3] = target_of(cmd_thr3);

    // A disarm in the same cycle wins over any handshake.
    assign accept_s = cmd_valid && ready_r && !disarm_req;

    assign period     = PERIOD_C;
    assign cmd_ready  = ready_r;
    assign frame_tick = tick_r;
    assign state      = state_r;
    assign duty0      = duty_r[0];
    assign duty1      = duty_r[1];
    assign duty2      = duty_r[2];
    assign duty3      = duty_r[3];

    // Frame counter wrap; frame_tick is registered so it lines up with the last count.
    always_comb begin
        cnt_s  = cnt_r + CW'(1);
        tick_s = 1'b0;
        if (cnt_r == LAST_C) begin
            cnt_s = {CW{1'b0}};
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
        tick_s = (cnt_s == LAST_C);
    end

    // Sequencer state, frame counts and shadow targets.
    always_comb begin
        state_s   = state_r;
        arm_cnt_s = arm_cnt_r;
        to_cnt_s  = to_cnt_r;
        restart_s = restart_r;
        shadow_s  = shadow_r;
        if (tick_r && (state_r == ST_ARMED)) begin
            restart_s = 1'b0;
        end else begin
            restart_s = restart_r;
        end
        if (disarm_req) begin
            state_s   = ST_DISARMED;
            arm_cnt_s = 16'd0;
            to_cnt_s  = 16'd0;
            restart_s = 1'b0;
        end else begin
            case (state_r)
                ST_DISARMED: begin
                    if (arm_req) begin
                        state_s   = ST_ARMING;
                        arm_cnt_s = 16'd0;
                    end else begin
                        state_s = ST_DISARMED;
                    end
                end
                ST_ARMING: begin
                    if (tick_r && (arm_cnt_r == ARM_LAST_C)) begin
                        state_s  = ST_ARMED;
                        to_cnt_s = 16'd0;
                        for (int i = 0; i < 4; i++) shadow_s[i] = MIN_C;
                    end else if (tick_r) begin
                        arm_cnt_s = arm_cnt_r + 16'd1;
                    end else begin
                        arm_cnt_s = arm_cnt_r;
                    end
                end
                ST_ARMED: begin
                    if (accept_s) begin
                        to_cnt_s = 16'd0;
                        shadow_s = tgt_s;
                    end else if (tick_r && (to_cnt_r == TO_LAST_C)) begin
                        state_s  = ST_FAILSAFE;
                        to_cnt_s = 16'd0;
                    end else if (tick_r) begin
                        to_cnt_s = to_cnt_r + 16'd1;
                    end else begin
                        to_cnt_s = to_cnt_r;
                    end
                end
                ST_FAILSAFE: begin
                    if (accept_s) begin
                        state_s   = ST_ARMED;
                        to_cnt_s  = 16'd0;
                        restart_s = 1'b1;
                        shadow_s  = tgt_s;
                    end else begin
                        state_s = ST_FAILSAFE;
                    end
                end
                default: begin
                    state_s = ST_DISARMED;
                end
            endcase
        end
        ready_s = (state_s == ST_ARMED) || (state_s == ST_FAILSAFE);
    end

    // Duty is only recomputed on the frame boundary, from the state held during frame_tick.
    always_comb begin
        duty_s = duty_r;
        if (tick_r) begin
            case (state_r)
                ST_DISARMED: begin
                    for (int i = 0; i < 4; i++) duty_s[i] = {CW{1'b0}};
                end
                ST_ARMED: begin
                    for (int i = 0; i < 4; i++)
                        duty_s[i] = slew(restart_r ? MIN_C : duty_r[i], shadow_r[i]);
                end
                ST_ARMING, ST_FAILSAFE: begin
                    for (int i = 0; i < 4; i++) duty_s[i] = MIN_C;
                end
                default: begin
                    for (int i = 0; i < 4; i++) duty_s[i] = {CW{1'b0}};
                end
            endcase
        end else begin
            duty_s = duty_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_DISARMED;
            cnt_r     <= {CW{1'b0}};
            tick_r    <= 1'b0;
            arm_cnt_r <= 16'd0;
            to_cnt_r  <= 16'd0;
            restart_r <= 1'b0;
            ready_r   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= MIN_C;
                duty_r[i]   <= {CW{1'b0}};
            end
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            tick_r    <= tick_s;
            arm_cnt_r <= arm_cnt_s;
            to_cnt_r  <= to_cnt_s;
            restart_r <= restart_s;
            ready_r   <= ready_s;
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= shadow_s[i];
                duty_r[i]   <= duty_s[i];
            end
        end
    end

endmodule

// File: tb/tb_esc_sequencer.sv
// Randomized scoreboard bench for esc_sequencer with a cycle-level reference
// model of the arming, timeout, clamping and slew rules.
module tb_esc_sequencer;

    localparam int P    = 100;
    localparam int MIN  = 10;
    localparam int TPU  = 1;
    localparam int MT   = 1000;
    localparam int STEP = 4;
    localparam int ARMF = 3;
    localparam int TOF  = 2;

    localparam int S_DIS = 0, S_ARMING = 1, S_ARMED = 2, S_FS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm_req = 1'b0, disarm_req = 1'b0, cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_thr0 = 11'd0, cmd_thr1 = 11'd0, cmd_thr2 = 11'd0, cmd_thr3 = 11'd0;
    logic [31:0] period, duty0, duty1, duty2, duty3;
    logic        frame_tick;
    logic [1:0]  state;

    esc_sequencer #(
        .CW(32), .PERIOD_TICKS(P), .MIN_TICKS(MIN), .TICKS_PER_UNIT(TPU),
        .MAX_THR(MT), .MAX_STEP(STEP), .ARM_FRAMES(ARMF), .TIMEOUT_FRAMES(TOF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm_req(arm_req), .disarm_req(disarm_req),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_thr0(cmd_thr0), .cmd_thr1(cmd_thr1), .cmd_thr2(cmd_thr2), .cmd_thr3(cmd_thr3),
        .period(period), .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
        .frame_tick(frame_tick), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic        rdy;
        logic        tick;
        logic [31:0] d0, d1, d2, d3;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference model: what the outputs show in the current cycle.
    int m_state, m_cnt, m_armcnt, m_idle;
    bit m_from_min;
    int m_shadow[4];
    int m_duty[4];
    int thr_v[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", state, e.st);
            chk("cmd_ready", cmd_ready, e.rdy);
            chk("frame_tick", frame_tick, e.tick);
            chk("duty0", duty0, e.d0);
            chk("duty1", duty1, e.d1);
            chk("duty2", duty2, e.d2);
            chk("duty3", duty3, e.d3);
            chk("period", period, P);
        end
    end

    task automatic model_reset();
        m_state = S_DIS; m_cnt = 0; m_armcnt = 0; m_idle = 0; m_from_min = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = MIN;
            m_duty[i]   = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.st   = 2'(m_state);
        e.rdy  = (m_state == S_ARMED) || (m_state == S_FS);
        e.tick = (m_cnt == P - 1);
        e.d0 = 32'(m_duty[0]); e.d1 = 32'(m_duty[1]);
        e.d2 = 32'(m_duty[2]); e.d3 = 32'(m_duty[3]);
        exp_q.push_back(e);
    endtask

    // Advance the model by one clock given the inputs applied during this cycle.
    task automatic model_step(input bit a, input bit d, input bit v);
        bit tick, acc;
        int from, diff;
        tick = (m_cnt == P - 1);
        acc  = v && (m_state >= S_ARMED) && !d;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (m_state == S_DIS) m_duty[i] = 0;
                else if (m_state == S_ARMED) begin
                    from = m_from_min ? MIN : m_duty[i];
                    diff = m_shadow[i] - from;
                    if (diff > STEP) diff = STEP;
                    if (diff < -STEP) diff = -STEP;
                    m_duty[i] = from + diff;
                end else m_duty[i] = MIN;
            end
            if (m_state == S_ARMED) m_from_min = 1'b0;
        end
        if (d) begin
            m_state = S_DIS; m_armcnt = 0; m_idle = 0; m_from_min = 1'b0;
        end else begin
            case (m_state)
                S_DIS: if (a) begin m_state = S_ARMING; m_armcnt = 0; end
                S_ARMING: if (tick) begin
                    m_armcnt++;
                    if (m_armcnt == ARMF) begin
                        m_state = S_ARMED; m_idle = 0;
                        for (int i = 0; i < 4; i++) m_shadow[i] = MIN;
                    end
                end
                S_ARMED: if (acc) begin
                    m_idle = 0;
                    for (int i = 0; i < 4; i++) m_shadow[i] = MIN + ((thr_v[i] > MT) ? MT : thr_v[i]) * TPU;
                end else if (tick) begin
                    m_idle++;
                    if (m_idle == TOF) begin m_state = S_FS; m_idle = 0; end
                end
                default: if (acc) begin
                    m_state = S_ARMED; m_idle = 0; m_from_min = 1'b1;
                    for (int i = 0; i < 4; i++) m_shadow[i] = MIN + ((thr_v[i] > MT) ? MT : thr_v[i]) * TPU;
                end
            endcase
        end
        m_cnt = (m_cnt + 1) % P;
    endtask

    task automatic cycle(input bit a, input bit d, input bit v);
        @(posedge clk); #1;
        push_exp();
        arm_req = a; disarm_req = d; cmd_valid = v;
        cmd_thr0 = 11'(thr_v[0]); cmd_thr1 = 11'(thr_v[1]);
        cmd_thr2 = 11'(thr_v[2]); cmd_thr3 = 11'(thr_v[3]);
        model_step(a, d, v);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset applied between clock edges, outputs checked while held.
    task automatic run_reset(input int n);
        @(negedge clk); #1;
        rst_n = 1'b0;
        arm_req = 1'b0; disarm_req = 1'b0; cmd_valid = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge clk); #1;
            push_exp();
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 4; i++) thr_v[i] = int'($urandom_range(0, 2047));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1499) == 0, $urandom_range(0, 29) == 0);
        end
    endtask

    initial begin
        thr_v = '{0, 0, 0, 0};
        model_reset();
        run_reset(5);
        idle(250);
        cycle(1'b1, 1'b0, 1'b0);
        idle(450);
        thr_v = '{30, 2000, 500, 0};
        cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 25; k++) begin
            idle(59);
            cycle(1'b0, 1'b0, 1'b1);
        end
        idle(350);
        thr_v = '{700, 3, 1000, 1500};
        cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            idle(69);
            cycle(1'b0, 1'b0, 1'b1);
        end
        cycle(1'b1, 1'b1, 1'b1);
        idle(250);
        random_run(5000);
        run_reset(3);
        idle(150);
        cycle(1'b1, 1'b0, 1'b0);
        random_run(1500);
        @(posedge clk); #1;
        push_exp();
        @(negedge clk); #1;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/esc_sequencer.md
ESC_SEQUENCER -- requirements
Module: esc_sequencer

Interface
REQ-001 SHALL have parameter CW, default 32, width of period/duty outputs.
REQ-002 SHALL have parameter PERIOD_TICKS, default 2000000, PWM frame length in clk cycles.
REQ-003 SHALL have parameter MIN_TICKS, default 100000, pulse width at throttle 0.
REQ-004 SHALL have parameter TICKS_PER_UNIT, default 100, pulse ticks per throttle unit.
REQ-005 SHALL have parameter MAX_THR, default 1000, maximum accepted throttle.
REQ-006 SHALL have parameter MAX_STEP, default 5000, maximum per-frame duty change in ticks.
REQ-007 SHALL have parameter ARM_FRAMES, default 100, frames of minimum pulse before the armed state.
REQ-008 SHALL have parameter TIMEOUT_FRAMES, default 25, frames without a command before failsafe.
REQ-009 clk  in  1  clock.
REQ-010 rst_n  in  1  reset; asynchronous, active-low.
REQ-011 arm_req  in  1  single-cycle request to start arming.
REQ-012 disarm_req  in  1  single-cycle request to disarm.
REQ-013 cmd_valid  in  1  throttle bundle valid.
REQ-014 cmd_ready  out  1  bundle accepted when cmd_valid && cmd_ready.
REQ-015 cmd_thr0..cmd_thr3  in  11 each  per-motor throttle, 0..MAX_THR.
REQ-016 period  out  CW  constant PERIOD_TICKS, to the PWM core.
REQ-017 duty0..duty3  out  CW each  pulse widths, to the PWM core.
REQ-018 frame_tick  out  1  one-cycle pulse on the last cycle of each frame.
REQ-019 state  out  2  0=DISARMED, 1=ARMING, 2=ARMED, 3=FAILSAFE.

Function
REQ-020 An internal frame counter SHALL count 0..PERIOD_TICKS-1 and wrap to 0; frame_tick SHALL be 1 exactly when the counter equals PERIOD_TICKS-1.
REQ-021 cmd_ready SHALL be 1 only in ARMED and FAILSAFE; in other states bundles SHALL be neither accepted nor stored.
REQ-022 An accepted throttle above MAX_THR SHALL be clamped to MAX_THR.
REQ-023 Target per motor SHALL be MIN_TICKS + thr*TICKS_PER_UNIT, computed at CW width without overflow for legal parameters.
REQ-024 Accepted targets SHALL go to a shadow register; a later accept before the next frame_tick SHALL overwrite it.
REQ-025 duty outputs SHALL change only in the cycle after frame_tick; no mid-frame change is allowed.
REQ-026 At each update in ARMED, each duty SHALL move toward its target by min(|target-duty|, MAX_STEP).
REQ-027 In DISARMED, duty SHALL be 0 (no pulse).
REQ-028 In ARMING and FAILSAFE, duty SHALL be MIN_TICKS at the next update, with no slew limit.
REQ-029 DISARMED->ARMING on arm_req; the frame count SHALL be cleared.
REQ-030 ARMING->ARMED after ARM_FRAMES frame_ticks; the shadow targets SHALL be initialised to MIN_TICKS.
REQ-031 ARMED->FAILSAFE when TIMEOUT_FRAMES consecutive frame_ticks occur with no accepted bundle; an accept SHALL clear the timeout count.
REQ-032 FAILSAFE->ARMED on an accepted bundle; the slew SHALL restart from MIN_TICKS.
REQ-033 disarm_req SHALL force DISARMED from any state on the next cycle and SHALL take priority over arm_req and accepts in the same cycle.
REQ-034 arm_req outside DISARMED SHALL be ignored.
REQ-035 The transition into DISARMED SHALL take effect on duty at the next update (frame boundary).

Reset
REQ-036 On rst_n low: state=DISARMED, frame counter=0, frame_tick=0, duty0..3=0, cmd_ready=0, shadow targets=MIN_TICKS, arming and timeout counts=0; period SHALL equal PERIOD_TICKS at all times.
REQ-037 Reset asserted mid-frame SHALL clear all state immediately; after release, the first frame_tick SHALL occur PERIOD_TICKS cycles later.

Verification (PERIOD_TICKS=100, MIN_TICKS=10, TICKS_PER_UNIT=1, MAX_STEP=4, ARM_FRAMES=3, TIMEOUT_FRAMES=2)
REQ-038 Reset released, no input -> frame_tick every 100 cycles, duty=0, state=0, cmd_ready=0.
REQ-039 arm_req -> state=1, duty=10 after the next frame; state=2 after 3 frame_ticks, with cmd_ready=1.
REQ-040 In ARMED, bundle thr0=30 -> duty0 goes 14, 18, 22, ..., 38, 40 on successive frames and never changes mid-frame.
REQ-041 thr1=2000 -> clamped; target 1010 is approached in steps of 4.
REQ-042 No bundle for 2 frames -> state=3 and duty=10; a new bundle -> state=2 with the slew restarting from 10.
REQ-043 disarm_req in the same cycle as arm_req and an accepted bundle -> state=0 next cycle, and duty=0 after the next frame_tick.
